vsmp_seq: RTL and testbench

- Instruction sequencer for the VSMP single-bus datapath.
- Runs the fetch/decode/execute sequence and performs the memory request/acknowledge handshake.
- Drives one-hot bus-source and bus-destination selects, PC increment, ALU enable and add/sub control.
- Sits between program memory, the datapath registers (PC, MAR, IR, A, B, OUT) and the ALU; replaces fixed 4-phase sequencing with variable-length, memory-wait-tolerant sequencing.

---
 rtl/vsmp_ctl_pkg.sv | 56 +++++
 rtl/vsmp_ctl_decode.sv | 81 ++++++++
 rtl/vsmp_seq.sv | 135 +++++++++++++
 tb/tb_vsmp_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vsmp_ctl_pkg.sv
// Shared constants for the VSMP instruction sequencer: opcodes, state codes and
// one-hot bus select bit positions.
package vsmp_ctl_pkg;

  localparam int unsigned OpcW = 4;

  localparam logic [OpcW-1:0] OpNop = 4'b0000;
  localparam logic [OpcW-1:0] OpAdd = 4'b0001;
  localparam logic [OpcW-1:0] OpSub = 4'b0010;
  localparam logic [OpcW-1:0] OpLda = 4'b0101;
  localparam logic [OpcW-1:0] OpJmp = 4'b0110;
  localparam logic [OpcW-1:0] OpOut = 4'b1110;
  localparam logic [OpcW-1:0] OpHlt = 4'b1111;

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StFwait  = 4'd2,
    StDecode = 4'd3,
    StOpaddr = 4'd4,
    StOwait  = 4'd5,
    StAlu    = 4'd6,
    StJump   = 4'd7,
    StOutp   = 4'd8,
    StHalt   = 4'd9,
    StErr    = 4'd10
  } state_e;

  // Bus driver select bit positions
  localparam int unsigned SrcW    = 5;
  localparam int unsigned SrcPc   = 0;
  localparam int unsigned SrcMem  = 1;
  localparam int unsigned SrcIrLo = 2;
  localparam int unsigned SrcAlu  = 3;
  localparam int unsigned SrcA    = 4;

  // Bus loader select bit positions
  localparam int unsigned DstW   = 6;
  localparam int unsigned DstMar = 0;
  localparam int unsigned DstIr  = 1;
  localparam int unsigned DstA   = 2;
  localparam int unsigned DstB   = 3;
  localparam int unsigned DstOut = 4;
  localparam int unsigned DstPc  = 5;

  function automatic logic [SrcW-1:0] src_sel(input int unsigned idx);
    return SrcW'(1) << idx;
  endfunction

  function automatic logic [DstW-1:0] dst_sel(input int unsigned idx);
    return DstW'(1) << idx;
  endfunction

endpackage

// File: rtl/vsmp_ctl_decode.sv
// Combinational control decode for the VSMP sequencer: maps (state, opcode,
// memory acknowledge) onto bus selects, memory request and ALU controls.
module vsmp_ctl_decode
  import vsmp_ctl_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  state_e             state,
  input  logic [OPC_W-1:0]   opc,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic [SrcW-1:0]    bus_src,
  output logic [DstW-1:0]    bus_dst,
  output logic               pc_inc,
  output logic               alu_en,
  output logic               add_sub,
  output logic               halted
);

  logic is_lda;
  logic is_sub;

  assign is_lda = (opc == OPC_W'(OpLda));
  assign is_sub = (opc == OPC_W'(OpSub));

  always_comb begin
    mem_req = 1'b0;
    bus_src = '0;
    bus_dst = '0;
    pc_inc  = 1'b0;
    alu_en  = 1'b0;
    add_sub = 1'b0;
    halted  = 1'b0;
    case (state)
      StFetch: begin
        bus_src = src_sel(SrcPc);
        bus_dst = dst_sel(DstMar);
        pc_inc  = 1'b1;
      end
      StFwait: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          bus_src = src_sel(SrcMem);
          bus_dst = dst_sel(DstIr);
        end
      end
      StOpaddr: begin
        bus_src = src_sel(SrcIrLo);
        bus_dst = dst_sel(DstMar);
      end
      StOwait: begin
        mem_req = 1'b1;
        // Only LDA/ADD/SUB reach the operand wait; LDA lands in A, the others in B
        if (mem_ack) begin
          bus_src = src_sel(SrcMem);
          bus_dst = is_lda ? dst_sel(DstA) : dst_sel(DstB);
        end
      end
      StAlu: begin
        bus_src = src_sel(SrcAlu);
        bus_dst = dst_sel(DstA);
        alu_en  = 1'b1;
        add_sub = is_sub;
      end
      StJump: begin
        bus_src = src_sel(SrcIrLo);
        bus_dst = dst_sel(DstPc);
      end
      StOutp: begin
        bus_src = src_sel(SrcA);
        bus_dst = dst_sel(DstOut);
      end
      StHalt, StErr: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/vsmp_seq.sv
// VSMP instruction sequencer top: state register, opcode register and the optional
// memory-acknowledge timeout enabled by VSMP_ACK_TIMEOUT_EN.
module vsmp_seq
  import vsmp_ctl_pkg::*;
#(
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RUN,
  input  logic [OPC_W-1:0]  INSTR,
  input  logic              MEM_ACK,
  output logic              MEM_REQ,
  output logic [SrcW-1:0]   BUS_SRC,
  output logic [DstW-1:0]   BUS_DST,
  output logic              PC_INC,
  output logic              ENABLEALU,
  output logic              ADDSUB,
  output logic [StateW-1:0] STATE,
  output logic              HALTED,
  output logic              ERR
);

  if (TIMEOUT_CYC >= (1 << TMO_W)) begin : g_tmo_check
    $error("TIMEOUT_CYC must be below 2**TMO_W");
  end

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic             in_wait;
  logic             tmo_hit;

  assign in_wait = (state_q == StFwait) || (state_q == StOwait);

`ifdef VSMP_ACK_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // Counter idles at zero outside the wait states, so it is fresh on every entry
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tmo_q <= '0;
    end else if (!in_wait) begin
      tmo_q <= '0;
    end else if (!MEM_ACK) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Fires on the edge that would bring the count of unacknowledged cycles to TIMEOUT_CYC
  assign tmo_hit = in_wait && !MEM_ACK && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign ERR     = (state_q == StErr);
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      opc_q <= '0;
    end else if ((state_q == StFwait) && MEM_ACK) begin
      opc_q <= INSTR;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (RUN) state_d = StFetch;
      StFetch:  state_d = StFwait;
      StFwait: begin
        if (tmo_hit) begin
          state_d = StErr;
        end else if (MEM_ACK) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (opc_q)
          OPC_W'(OpHlt): state_d = StHalt;
          OPC_W'(OpAdd),
          OPC_W'(OpSub),
          OPC_W'(OpLda): state_d = StOpaddr;
          OPC_W'(OpJmp): state_d = StJump;
          OPC_W'(OpOut): state_d = StOutp;
          default:       state_d = StFetch;
        endcase
      end
      StOpaddr: state_d = StOwait;
      StOwait: begin
        if (tmo_hit) begin
          state_d = StErr;
        end else if (MEM_ACK) begin
          state_d = (opc_q == OPC_W'(OpLda)) ? StFetch : StAlu;
        end
      end
      StAlu, StJump, StOutp: state_d = StFetch;
      StHalt:   if (RUN) state_d = StFetch;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  vsmp_ctl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state   (state_q),
    .opc     (opc_q),
    .mem_ack (MEM_ACK),
    .mem_req (MEM_REQ),
    .bus_src (BUS_SRC),
    .bus_dst (BUS_DST),
    .pc_inc  (PC_INC),
    .alu_en  (ENABLEALU),
    .add_sub (ADDSUB),
    .halted  (HALTED)
  );

  assign STATE = state_q;

  a_src_onehot : assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(BUS_SRC));
  a_dst_onehot : assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(BUS_DST));
  a_req_wait   : assert property (@(posedge CLK) disable iff (!RSTN) MEM_REQ |-> in_wait);
  a_err_halted : assert property (@(posedge CLK) disable iff (!RSTN) ERR |-> HALTED);

endmodule

// File: tb/tb_vsmp_seq.sv
// Scoreboard bench for vsmp_seq: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_vsmp_seq;

  logic       CLK;
  logic       RSTN;
  logic       RUN;
  logic [3:0] INSTR;
  logic       MEM_ACK;
  logic       MEM_REQ;
  logic [4:0] BUS_SRC;
  logic [5:0] BUS_DST;
  logic       PC_INC;
  logic       ENABLEALU;
  logic       ADDSUB;
  logic [3:0] STATE;
  logic       HALTED;
  logic       ERR;

  vsmp_seq dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .RUN       (RUN),
    .INSTR     (INSTR),
    .MEM_ACK   (MEM_ACK),
    .MEM_REQ   (MEM_REQ),
    .BUS_SRC   (BUS_SRC),
    .BUS_DST   (BUS_DST),
    .PC_INC    (PC_INC),
    .ENABLEALU (ENABLEALU),
    .ADDSUB    (ADDSUB),
    .STATE     (STATE),
    .HALTED    (HALTED),
    .ERR       (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // State codes
  localparam logic [3:0] I = 4'd0, F = 4'd1, FW = 4'd2, D = 4'd3, OA = 4'd4, OW = 4'd5;
  localparam logic [3:0] AL = 4'd6, J = 4'd7, O = 4'd8, H = 4'd9, E = 4'd10;
  // Bus sources / destinations
  localparam logic [4:0] SP = 5'b00001, SM = 5'b00010, SI = 5'b00100, SAL = 5'b01000;
  localparam logic [4:0] SA = 5'b10000;
  localparam logic [5:0] DMAR = 6'b000001, DIR = 6'b000010, DA = 6'b000100, DB = 6'b001000;
  localparam logic [5:0] DO = 6'b010000, DPC = 6'b100000;
  // Flags {req, inc, alu, sub, hlt, err}
  localparam logic [5:0] FREQ = 6'b100000, FINC = 6'b010000, FALU = 6'b001000;
  localparam logic [5:0] FSUB = 6'b000100, FHLT = 6'b000010, FERR = 6'b000001;
  // Opcodes
  localparam logic [3:0] NOP = 4'b0000, ADD = 4'b0001, SUB = 4'b0010, LDA = 4'b0101;
  localparam logic [3:0] JMP = 4'b0110, OUT = 4'b1110, HLT = 4'b1111;

  typedef struct {
    int          tag;
    logic [20:0] v;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tag_ctr  = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge and queue what the DUT must show
  task automatic cyc(input logic run, input logic ack, input logic [3:0] ins,
                     input logic [3:0] st, input logic [4:0] src, input logic [5:0] dst,
                     input logic [5:0] fl);
    exp_t e;
    @(posedge CLK);
    #1;
    RUN     = run;
    MEM_ACK = ack;
    INSTR   = ins;
    e.tag   = tag_ctr;
    e.v     = {st, src, dst, fl};
    tag_ctr++;
    expq.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      check("cycle", e.tag,
            32'({STATE, BUS_SRC, BUS_DST, MEM_REQ, PC_INC, ENABLEALU, ADDSUB, HALTED, ERR}),
            32'(e.v));
    end
    if (RSTN) begin
      check("onehot", tag_ctr, 32'($onehot0(BUS_SRC) && $onehot0(BUS_DST)), 32'd1);
    end
  end

  initial begin
    RSTN    = 1'b0;
    RUN     = 1'b0;
    MEM_ACK = 1'b0;
    INSTR   = 4'd0;

    cyc(0, 0, 0, I, 0, 0, 0);
    RSTN = 1'b1;
    cyc(1, 0, 0, I, 0, 0, 0);

    // LDA, single-cycle acknowledge
    cyc(0, 0, 0,   F,  SP, DMAR, FINC);
    cyc(0, 1, LDA, FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,   D,  0,  0,    0);
    cyc(0, 0, 0,   OA, SI, DMAR, 0);
    cyc(0, 1, HLT, OW, SM, DA,   FREQ);

    // SUB: ACK delayed 3 cycles in FWAIT, 2 in OWAIT
    cyc(0, 0, 0, F, SP, DMAR, FINC);
    for (int i = 0; i < 3; i++) cyc(0, 0, HLT, FW, 0, 0, FREQ);
    cyc(0, 1, SUB, FW, SM, DIR, FREQ);
    cyc(0, 0, 0, D, 0, 0, 0);
    cyc(0, 0, 0, OA, SI, DMAR, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, OW, 0, 0, FREQ);
    cyc(0, 1, 0, OW, SM, DB, FREQ);
    cyc(0, 0, 0, AL, SAL, DA, FALU | FSUB);

    // JMP then OUT
    cyc(0, 0, 0,   F,  SP, DMAR, FINC);
    cyc(0, 1, JMP, FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,   D,  0,  0,    0);
    cyc(0, 0, 0,   J,  SI, DPC,  0);
    cyc(0, 0, 0,   F,  SP, DMAR, FINC);
    cyc(0, 1, OUT, FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,   D,  0,  0,    0);
    cyc(0, 0, 0,   O,  SA, DO,   0);

    // NOP, then an undefined opcode behaving as NOP
    cyc(0, 0, 0,     F,  SP, DMAR, FINC);
    cyc(0, 1, NOP,   FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,     D,  0,  0,    0);
    cyc(0, 0, 0,     F,  SP, DMAR, FINC);
    cyc(0, 1, 4'h3,  FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,     D,  0,  0,    0);

    // ADD with RUN held high throughout
    cyc(1, 0, 0,   F,  SP,  DMAR, FINC);
    cyc(1, 1, ADD, FW, SM,  DIR,  FREQ);
    cyc(1, 0, 0,   D,  0,   0,    0);
    cyc(1, 0, 0,   OA, SI,  DMAR, 0);
    cyc(1, 1, 0,   OW, SM,  DB,   FREQ);
    cyc(1, 0, 0,   AL, SAL, DA,   FALU);

    // HLT, stay halted with RUN low (stray ACKs ignored), resume
    cyc(0, 0, 0,   F,  SP, DMAR, FINC);
    cyc(0, 1, HLT, FW, SM, DIR,  FREQ);
    cyc(0, 1, 0,   D,  0,  0,    0);
    for (int i = 0; i < 10; i++) cyc(0, i[0], 0, H, 0, 0, FHLT);
    cyc(1, 0, 0, H, 0, 0, FHLT);
    cyc(0, 0, 0, F, SP, DMAR, FINC);

    // LDA interrupted by reset in OWAIT
    cyc(0, 1, LDA, FW, SM, DIR,  FREQ);
    cyc(0, 0, 0,   D,  0,  0,    0);
    cyc(0, 0, 0,   OA, SI, DMAR, 0);
    cyc(0, 0, 0,   OW, 0,  0,    FREQ);
    #6;
    RSTN = 1'b0;
    #1;
    check("async_rst", tag_ctr, 32'({STATE, MEM_REQ}), 32'({I, 1'b0}));
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, LDA, I, 0, 0, 0);
    cyc(0, 0, 0, I, 0, 0, 0);

`ifdef VSMP_ACK_TIMEOUT_EN
    // Timeout: 15 unacknowledged FWAIT cycles, then ERR is sticky until reset
    cyc(1, 0, 0, I, 0, 0, 0);
    cyc(0, 0, 0, F, SP, DMAR, FINC);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, FW, 0, 0, FREQ);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, E, 0, 0, FHLT | FERR);
    #6;
    RSTN = 1'b0;
    #1;
    check("err_rst", tag_ctr, 32'({STATE, ERR}), 32'({I, 1'b0}));
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    RUN  = 1'b0;
    cyc(0, 0, 0, I, 0, 0, 0);
`endif

    @(posedge CLK);
    @(posedge CLK);
    check("drain", tag_ctr, 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
